// File: rtl/cc_receive.sv
// cc_receive: 8N1 serial byte receiver that fills a subframe buffer.
//
// Bytes arriving on rx (idle high, LSB first) are written to an external
// buffer at consecutive addresses. When SUBFRAME bytes have been written the
// address wraps to 0 and done pulses. A stop-bit error or a stall of IDLE_TO
// clocks partway through a subframe pulses frame_err. A stall also restarts
// the subframe at address 0.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-high reset
//   rx         serial input from cc_transmit tx
//   wraddress  buffer write address (12 bits)
//   wrdata     received byte, held between writes
//   wren       one-cycle buffer write strobe
//   done       one-cycle pulse when a subframe completes
//   frame_err  one-cycle pulse on stop-bit error or idle timeout
//   busy       high whenever the receiver is not idle
module cc_receive #(
  parameter int unsigned BIT_CYC  = 50,
  parameter int unsigned SUBFRAME = 2048,
  parameter int unsigned IDLE_TO  = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic [11:0] wraddress,
  output logic [7:0]  wrdata,
  output logic        wren,
  output logic        done,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned TW = $clog2(BIT_CYC + 1);
  localparam int unsigned IW = $clog2(IDLE_TO + 1);

  localparam logic [TW-1:0] HALF_LAST = TW'(BIT_CYC / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_CYC - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TO - 1);
  localparam logic [12:0]   SUB_LAST  = 13'(SUBFRAME - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e        state_q;
  logic          rx_meta_q;
  logic          rxs;
  logic [TW-1:0] bit_tmr_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic [12:0]   byte_cnt_q;
  logic [IW-1:0] idle_tmr_q;

  // Synchronizer resets high so reset release never looks like a start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs       <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs       <= rx_meta_q;
    end
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_tmr_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      idle_tmr_q <= '0;
      wraddress  <= '0;
      wrdata     <= '0;
      wren       <= 1'b0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      wren      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;

      // Advance the buffer position the cycle after each write.
      if (wren) begin
        if (byte_cnt_q == SUB_LAST) begin
          byte_cnt_q <= '0;
          wraddress  <= '0;
          done       <= 1'b1;
        end else begin
          byte_cnt_q <= byte_cnt_q + 13'd1;
          wraddress  <= wraddress + 12'd1;
        end
      end

      case (state_q)
        StIdle: begin
          if (!rxs) begin
            state_q    <= StStart;
            bit_tmr_q  <= '0;
            idle_tmr_q <= '0;
          end else if (byte_cnt_q != '0) begin
            // Stall partway through a subframe: abandon it. Placed after the
            // write-advance above so the clear wins if both ever coincide.
            if (idle_tmr_q == IDLE_LAST) begin
              frame_err  <= 1'b1;
              byte_cnt_q <= '0;
              wraddress  <= '0;
              idle_tmr_q <= '0;
            end else begin
              idle_tmr_q <= idle_tmr_q + 1'b1;
            end
          end else begin
            idle_tmr_q <= '0;
          end
        end

        StStart: begin
          // Re-check the line mid start bit to reject glitches.
          if (bit_tmr_q == HALF_LAST) begin
            if (!rxs) begin
              state_q   <= StData;
              bit_tmr_q <= '0;
              bit_idx_q <= '0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            bit_tmr_q <= bit_tmr_q + 1'b1;
          end
        end

        StData: begin
          if (bit_tmr_q == BIT_LAST) begin
            shift_q[bit_idx_q] <= rxs;
            bit_tmr_q          <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            bit_tmr_q <= bit_tmr_q + 1'b1;
          end
        end

        StStop: begin
          if (bit_tmr_q == BIT_LAST) begin
            bit_tmr_q <= '0;
            if (rxs) begin
              wren    <= 1'b1;
              wrdata  <= shift_q;
              state_q <= StIdle;
            end else begin
              frame_err <= 1'b1;
              state_q   <= StWaitHigh;
            end
          end else begin
            bit_tmr_q <= bit_tmr_q + 1'b1;
          end
        end

        StWaitHigh: begin
          if (rxs) begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cc_receive.sv
// Self-checking bench for cc_receive: randomized 8N1 frames against a
// queue-based model of buffer writes, subframe completion and error pulses.
module tb_cc_receive;

  localparam int unsigned BitCyc   = 20;
  localparam int unsigned Subframe = 32;
  localparam int unsigned IdleTo   = 256;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx    = 1'b1;
  logic [11:0] wraddress;
  logic [7:0]  wrdata;
  logic        wren;
  logic        done;
  logic        frame_err;
  logic        busy;

  cc_receive #(
    .BIT_CYC (BitCyc),
    .SUBFRAME(Subframe),
    .IDLE_TO (IdleTo)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .wraddress(wraddress),
    .wrdata   (wrdata),
    .wren     (wren),
    .done     (done),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  int unsigned done_seen  = 0;
  int unsigned ferr_seen  = 0;
  int unsigned pulse_viol = 0;
  int unsigned hold_viol  = 0;
  longint      cyc        = 0;
  longint      last_wren_cyc = 0;
  longint      last_ferr_cyc = 0;
  logic        prev_wren, prev_done, prev_ferr;
  logic [7:0]  prev_data;

  // Model of the buffer position and expected pulse counts.
  int unsigned exp_addr = 0;
  int unsigned exp_done = 0;
  int unsigned exp_ferr = 0;

  // Monitor: samples on the falling edge, away from DUT updates.
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (reset) begin
      prev_wren = 1'b0;
      prev_done = 1'b0;
      prev_ferr = 1'b0;
      prev_data = wrdata;
    end else begin
      if (wren) begin
        got_q.push_back({wraddress, wrdata});
        last_wren_cyc = cyc;
      end
      if (done) done_seen++;
      if (frame_err) begin
        ferr_seen++;
        last_ferr_cyc = cyc;
      end
      if ((wren && prev_wren) || (done && prev_done) || (frame_err && prev_ferr)) pulse_viol++;
      if (!wren && (wrdata !== prev_data)) hold_viol++;
      prev_wren = wren;
      prev_done = done;
      prev_ferr = frame_err;
      prev_data = wrdata;
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Line driver: start bit BitCyc clocks, data bits BitCyc or BitCyc+1.
  task automatic send_byte(input logic [7:0] d, input logic stop, input int unsigned gap);
    rx = 1'b0;
    tick(BitCyc);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(BitCyc + $urandom_range(0, 1));
    end
    rx = stop;
    tick(BitCyc + 1);
    rx = 1'b1;
    tick(gap);
  endtask

  task automatic model_byte(input logic [7:0] d);
    exp_q.push_back({12'(exp_addr), d});
    exp_addr++;
    if (exp_addr == Subframe) begin
      exp_addr = 0;
      exp_done++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    tick(4);
    tests_run++;
    if (wraddress !== 12'd0) begin
      tests_failed++;
      $display("FAIL reset_wraddress: got %0h expected 0", wraddress);
    end
    tests_run++;
    if (wrdata !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_wrdata: got %0h expected 0", wrdata);
    end
    tests_run++;
    if ({wren, done, frame_err, busy} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_strobes: got %b expected 0000", {wren, done, frame_err, busy});
    end
    reset = 1'b0;
    tick(8);
    tests_run++;
    if ({busy, wren, frame_err} !== 3'b000 || got_q.size() != 0) begin
      tests_failed++;
      $display("FAIL reset_release: got busy/wren/ferr %b writes %0d expected 000 0",
               {busy, wren, frame_err}, got_q.size());
    end
  endtask

  task automatic test_single_byte();
    got_q.delete();
    exp_q.delete();
    send_byte(8'hA5, 1'b1, 6);
    model_byte(8'hA5);
    tests_run++;
    if (got_q.size() != 1) begin
      tests_failed++;
      $display("FAIL single_count: got %0d writes expected 1", got_q.size());
    end else begin
      tests_run++;
      if (got_q[0] !== exp_q[0]) begin
        tests_failed++;
        $display("FAIL single_write: got addr %0d data %0h expected addr %0d data %0h",
                 got_q[0].addr, got_q[0].data, exp_q[0].addr, exp_q[0].data);
      end
    end
    tests_run++;
    if (wraddress !== 12'(exp_addr)) begin
      tests_failed++;
      $display("FAIL single_next_addr: got %0d expected %0d", wraddress, exp_addr);
    end
  endtask

  task automatic test_glitch();
    got_q.delete();
    rx = 1'b0;
    tick(BitCyc / 4);
    rx = 1'b1;
    tick(BitCyc);
    tests_run++;
    if (got_q.size() != 0 || ferr_seen != exp_ferr || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch: got writes %0d ferr %0d busy %b expected 0 %0d 0",
               got_q.size(), ferr_seen, busy, exp_ferr);
    end
  endtask

  task automatic test_bad_stop();
    got_q.delete();
    exp_q.delete();
    send_byte(8'h3C, 1'b0, 6);
    exp_ferr++;
    tests_run++;
    if (ferr_seen != exp_ferr || got_q.size() != 0) begin
      tests_failed++;
      $display("FAIL bad_stop: got ferr %0d writes %0d expected %0d 0",
               ferr_seen, got_q.size(), exp_ferr);
    end
    send_byte(8'h11, 1'b1, 6);
    model_byte(8'h11);
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL after_bad_stop: got %0d writes first %0h expected 1 write %0h",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 20'h0, exp_q[0]);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    longint     dly;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      send_byte(d, 1'b1, $urandom_range(2, 20));
      model_byte(d);
    end
    tick(IdleTo + 2 * BitCyc);
    exp_addr = 0;
    exp_ferr++;
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL timeout_writes: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL timeout_write%0d: got %0h expected %0h", i, got_q[i], exp_q[i]);
        end
      end
    end
    tests_run++;
    if (ferr_seen != exp_ferr || done_seen != exp_done) begin
      tests_failed++;
      $display("FAIL timeout_pulses: got ferr %0d done %0d expected %0d %0d",
               ferr_seen, done_seen, exp_ferr, exp_done);
    end
    dly = last_ferr_cyc - last_wren_cyc;
    tests_run++;
    if (dly < longint'(IdleTo) - 1 || dly > longint'(IdleTo) + 1) begin
      tests_failed++;
      $display("FAIL timeout_delay: got %0d clocks expected %0d +/-1", dly, IdleTo);
    end
    tests_run++;
    if (wraddress !== 12'(exp_addr)) begin
      tests_failed++;
      $display("FAIL timeout_addr: got %0d expected %0d", wraddress, exp_addr);
    end
    got_q.delete();
    exp_q.delete();
    d = 8'($urandom);
    send_byte(d, 1'b1, 6);
    model_byte(d);
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL timeout_next: got %0d writes first %0h expected 1 write %0h",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 20'h0, exp_q[0]);
    end
  endtask

  // Random bytes with occasional bad stop bits until a subframe completes.
  task automatic test_subframe();
    logic [7:0]  d;
    int unsigned done0;
    int unsigned n;
    got_q.delete();
    exp_q.delete();
    done0 = exp_done;
    n     = 0;
    while (exp_done == done0 && n < 4 * Subframe) begin
      d = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        send_byte(d, 1'b0, $urandom_range(2, 12));
        exp_ferr++;
      end else begin
        send_byte(d, 1'b1, $urandom_range(2, 12));
        model_byte(d);
      end
      n++;
    end
    tick(4);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL subframe_writes: got %0d expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        tests_run++;
        if (got_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL subframe_write%0d: got %0h expected %0h", i, got_q[i], exp_q[i]);
        end
      end
    end
    tests_run++;
    if (done_seen != exp_done || ferr_seen != exp_ferr) begin
      tests_failed++;
      $display("FAIL subframe_pulses: got done %0d ferr %0d expected %0d %0d",
               done_seen, ferr_seen, exp_done, exp_ferr);
    end
    tests_run++;
    if (wraddress !== 12'(exp_addr)) begin
      tests_failed++;
      $display("FAIL subframe_wrap: got %0d expected %0d", wraddress, exp_addr);
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] d;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom);
      send_byte(d, 1'b1, 4);
      model_byte(d);
    end
    d  = 8'h5A;
    rx = 1'b0;
    tick(BitCyc);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      tick(BitCyc);
    end
    rx = d[3];
    tick(BitCyc / 2);
    reset = 1'b1;
    #1;
    tests_run++;
    if ({wraddress, wrdata, wren, done, frame_err, busy} !== 24'd0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got addr %0d data %0h strobes %b expected all 0",
               wraddress, wrdata, {wren, done, frame_err, busy});
    end
    rx = 1'b1;
    tick(5);
    reset = 1'b0;
    exp_addr = 0;
    got_q.delete();
    exp_q.delete();
    tick(3 * BitCyc);
    tests_run++;
    if (got_q.size() != 0 || ferr_seen != exp_ferr || done_seen != exp_done) begin
      tests_failed++;
      $display("FAIL midreset_quiet: got writes %0d ferr %0d done %0d expected 0 %0d %0d",
               got_q.size(), ferr_seen, done_seen, exp_ferr, exp_done);
    end
    d = 8'($urandom);
    send_byte(d, 1'b1, 6);
    model_byte(d);
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL midreset_next: got %0d writes first %0h expected 1 write %0h",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 20'h0, exp_q[0]);
    end
  endtask

  task automatic test_pulse_rules();
    tests_run++;
    if (pulse_viol != 0) begin
      tests_failed++;
      $display("FAIL pulse_width: got %0d multi-cycle pulses expected 0", pulse_viol);
    end
    tests_run++;
    if (hold_viol != 0) begin
      tests_failed++;
      $display("FAIL wrdata_hold: got %0d changes without wren expected 0", hold_viol);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_bad_stop();
    test_timeout();
    test_subframe();
    test_reset_mid_byte();
    test_pulse_rules();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cc_receive.md
CC_RECEIVE -- requirements
Module: cc_receive

Interface
REQ-001 Parameter BIT_CYC, default 50: clocks per serial bit period.
REQ-002 Parameter SUBFRAME, default 2048: bytes per subframe.
REQ-003 Parameter IDLE_TO, default 1024: clocks of high line mid-subframe before abort.
REQ-004 clock  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rx  input  1  serial line from cc_transmit tx; idles high; 8N1 framing, LSB first.
REQ-007 wraddress  output  12  subframe buffer write address.
REQ-008 wrdata  output  8  received byte.
REQ-009 wren  output  1  one-cycle buffer write strobe.
REQ-010 done  output  1  one-cycle pulse on subframe completion.
REQ-011 frame_err  output  1  one-cycle pulse on framing error or timeout abort.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 rx SHALL pass a 2-flop synchronizer; all logic uses the synchronized value rxs.
REQ-014 States SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: on rxs==0 go to START and clear the bit-timer.
REQ-016 START: at timer==BIT_CYC/2-1 sample rxs; if 0 go to DATA and clear the timer and bit index; if 1 (glitch) return to IDLE with no output.
REQ-017 DATA: sample rxs each time timer==BIT_CYC-1, shift it into bit [index] of the shift register (LSB first), and clear the timer; after index 7 go to STOP.
REQ-018 STOP: at timer==BIT_CYC-1 sample rxs; if 1, on the next cycle drive wrdata=shift register and wren=1 with the current wraddress, then go to IDLE.
REQ-019 STOP sample 0 SHALL pulse frame_err for one cycle, discard the byte without a write, and go to WAIT_HIGH.
REQ-020 WAIT_HIGH: remain until rxs==1, then go to IDLE.
REQ-021 The cycle after each wren, wraddress SHALL increment by 1 and the 13-bit byte counter by 1.
REQ-022 When the counter reaches SUBFRAME, done SHALL pulse in the same cycle the counter is cleared and wraddress wraps to 0; done coincides with the cycle after the final wren.
REQ-023 Timeout: if the counter is nonzero and the state is IDLE for IDLE_TO consecutive clocks, pulse frame_err and clear both the counter and wraddress; done SHALL NOT pulse.
REQ-024 The idle timer SHALL clear on any transition out of IDLE.
REQ-025 The receiver SHALL tolerate a data-bit period of up to BIT_CYC+1 clocks and a start bit of BIT_CYC clocks, which is the cc_transmit timing with delay_val=48.
REQ-026 wren, done, and frame_err SHALL never assert for more than one cycle; wrdata SHALL hold its value between writes.

Reset
REQ-027 Reset SHALL drive wraddress=0, wrdata=0, wren=0, done=0, frame_err=0, busy=0, state=IDLE, and clear all counters and the shift register.
REQ-028 Synchronizer flops SHALL reset to 1 so that no false start is detected on reset release.
REQ-029 Reset mid-byte or mid-subframe SHALL abandon the partial data with no wren, done, or frame_err pulse.

Verification
REQ-030 Single byte 0xA5 with standard timing -> exactly one wren, wrdata=0xA5, wraddress=0; the following cycle wraddress=1.
REQ-031 cc_transmit instance (RDY pulse, SUBFRAME=2048) driving rx -> 2048 wren pulses, data matches the source buffer, done pulses once, wraddress=0 afterwards.
REQ-032 rx low for 10 clocks, then high -> no wren, no frame_err; state back to IDLE.
REQ-033 Byte 0x3C with the stop bit forced to 0 -> frame_err pulse, no wren; a 0x11 frame sent after rx returns high is written at an unchanged wraddress.
REQ-034 5 bytes, then rx held high for 1024 clocks -> frame_err pulse, wraddress=0; the next byte is written at address 0.
REQ-035 Reset asserted mid-DATA of byte 3 -> all outputs at reset values; a new byte after release is written at address 0.
